// File: rtl/magnitude_pkg.sv
// rtl/magnitude_pkg.sv - shared types and relation select for the serial magnitude comparator
// Contents:
//   mag_mode_t  : relation encoding on the 3-bit mode input (6 and 7 are reserved)
//   mag_state_t : comparator FSM states
//   mag_select  : maps a latched mode plus the gt/lt decision onto the result bit
package magnitude_pkg;

    typedef enum logic [2:0] {
        MAG_LT = 3'd0,
        MAG_GT = 3'd1,
        MAG_EQ = 3'd2,
        MAG_NE = 3'd3,
        MAG_LE = 3'd4,
        MAG_GE = 3'd5
    } mag_mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } mag_state_t;

    // Reserved modes fall through to 0.
    function automatic logic mag_select(input logic [2:0] mode, input logic gt, input logic lt);
        logic eq;
        eq = ~gt & ~lt;
        case (mode)
            MAG_LT:  return lt;
            MAG_GT:  return gt;
            MAG_EQ:  return eq;
            MAG_NE:  return ~eq;
            MAG_LE:  return lt | eq;
            MAG_GE:  return gt | eq;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mag_bit_step.sv
// rtl/mag_bit_step.sv - one MSB-first bit of the serial magnitude decision
// Ports:
//   a_bit, b_bit   in  : current operand bits
//   gt_in, lt_in   in  : decision so far (at most one set)
//   is_msb         in  : high on the first (sign) bit of the comparison
//   gt_out, lt_out out : updated decision
// Macro SERIAL_MAGNITUDE_SIGNED_EN: treat the MSB as a two's complement sign bit.
module mag_bit_step (
    input  logic a_bit,
    input  logic b_bit,
    input  logic gt_in,
    input  logic lt_in,
    input  logic is_msb,
    output logic gt_out,
    output logic lt_out
);

    logic decided;
    logic bit_gt;
    logic bit_lt;

    assign decided = gt_in | lt_in;

`ifdef SERIAL_MAGNITUDE_SIGNED_EN
    // A set sign bit means the operand is the smaller one, so the MSB rule is inverted.
    assign bit_gt = is_msb ? (~a_bit & b_bit) : (a_bit & ~b_bit);
    assign bit_lt = is_msb ? (a_bit & ~b_bit) : (~a_bit & b_bit);
`else
    logic unused_is_msb;
    assign unused_is_msb = is_msb;
    assign bit_gt = a_bit & ~b_bit;
    assign bit_lt = ~a_bit & b_bit;
`endif

    // The first differing bit decides; later bits cannot override it.
    assign gt_out = gt_in | (~decided & bit_gt);
    assign lt_out = lt_in | (~decided & bit_lt);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - bit-serial MSB-first magnitude comparator with start/done handshake
// Parameters:
//   WIDTH (>= 2) : operand width
// Ports:
//   clk, reset            in  : clock, synchronous active-high reset
//   start                 in  : request a comparison (honoured only when idle)
//   a, b [WIDTH]          in  : operands, captured with start
//   mode [3]              in  : relation select, captured with start
//   busy                  out : comparison in flight (COMPARE or DONE)
//   done                  out : one-cycle pulse, result valid
//   result                out : selected relation, held until next completion
//   a_gt_b/a_lt_b/a_eq_b  out : raw one-hot flags, held with result
// Macro SERIAL_MAGNITUDE_SIGNED_EN: two's complement operands (handled in mag_bit_step).
module serial_magnitude_comparator
    import magnitude_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             a_eq_b
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] MSB_CNT = CW'(WIDTH - 1);

    mag_state_t       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [2:0]       mode_q, mode_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             result_q, result_d;
    logic             a_gt_b_q, a_gt_b_d;
    logic             a_lt_b_q, a_lt_b_d;
    logic             a_eq_b_q, a_eq_b_d;

    logic step_gt;
    logic step_lt;

    // The counter starts at WIDTH-1, so that value marks the sign bit.
    mag_bit_step u_step (
        .a_bit  (sa_q[WIDTH-1]),
        .b_bit  (sb_q[WIDTH-1]),
        .gt_in  (gt_q),
        .lt_in  (lt_q),
        .is_msb (cnt_q == MSB_CNT),
        .gt_out (step_gt),
        .lt_out (step_lt)
    );

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        mode_d   = mode_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        a_gt_b_d = a_gt_b_q;
        a_lt_b_d = a_lt_b_q;
        a_eq_b_d = a_eq_b_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    mode_d  = mode;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    cnt_d   = MSB_CNT;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                gt_d = step_gt;
                lt_d = step_lt;
                sa_d = sa_q << 1;
                sb_d = sb_q << 1;
                if (cnt_q == '0) begin
                    // Output registers load on entry to DONE so they are
                    // valid in the same cycle as the done pulse.
                    state_d  = DONE;
                    done_d   = 1'b1;
                    a_gt_b_d = step_gt;
                    a_lt_b_d = step_lt;
                    a_eq_b_d = ~step_gt & ~step_lt;
                    result_d = mag_select(mode_q, step_gt, step_lt);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            mode_q   <= '0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= 1'b0;
            a_gt_b_q <= 1'b0;
            a_lt_b_q <= 1'b0;
            a_eq_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            mode_q   <= mode_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            a_gt_b_q <= a_gt_b_d;
            a_lt_b_q <= a_lt_b_d;
            a_eq_b_q <= a_eq_b_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign a_gt_b = a_gt_b_q;
    assign a_lt_b = a_lt_b_q;
    assign a_eq_b = a_eq_b_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - scoreboard bench for serial_magnitude_comparator
module tb_serial_magnitude_comparator;

    localparam int WIDTH = 8;

    typedef struct {
        logic [3:0] flags;   // {result, gt, lt, eq}
        int         cyc;     // cycle on which done must be seen
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [2:0]       mode = '0;
    logic             busy, done, result, a_gt_b, a_lt_b, a_eq_b;

    logic       s3_start = 1'b0;
    logic [2:0] s3_a = '0;
    logic [2:0] s3_b = '0;
    logic [2:0] s3_mode = '0;
    logic       s3_busy, s3_done, s3_result, s3_gt, s3_lt, s3_eq;

    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    exp_t sb_q[$];

    serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .mode(mode),
        .busy(busy), .done(done), .result(result),
        .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b)
    );

    serial_magnitude_comparator #(.WIDTH(3)) dut3 (
        .clk(clk), .reset(reset), .start(s3_start), .a(s3_a), .b(s3_b), .mode(s3_mode),
        .busy(s3_busy), .done(s3_done), .result(s3_result),
        .a_gt_b(s3_gt), .a_lt_b(s3_lt), .a_eq_b(s3_eq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: relation computed directly from integer ordering.
    function automatic logic [3:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                         input logic [2:0] mm);
        logic gt, lt, eq, r;
`ifdef SERIAL_MAGNITUDE_SIGNED_EN
        gt = $signed(ma) > $signed(mb);
        lt = $signed(ma) < $signed(mb);
`else
        gt = ma > mb;
        lt = ma < mb;
`endif
        eq = (ma == mb);
        case (mm)
            3'd0:    r = lt;
            3'd1:    r = gt;
            3'd2:    r = eq;
            3'd3:    r = !eq;
            3'd4:    r = lt || eq;
            3'd5:    r = gt || eq;
            default: r = 1'b0;
        endcase
        return {r, gt, lt, eq};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("result_flags", {result, a_gt_b, a_lt_b, a_eq_b}, e.flags);
                end
            end
        end
    endtask

    // Called just after a negedge; returns just after the negedge following
    // the DONE-to-IDLE edge so the next start is sampled in IDLE.
    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic [2:0] im);
        start = 1'b1; a = ia; b = ib; mode = im;
        @(posedge clk); #1;
        start = 1'b0;
        sb_q.push_back('{model(ia, ib, im), cyc + WIDTH});
        check("busy_after_start", busy, 1);
        a = WIDTH'($urandom); b = WIDTH'($urandom); mode = 3'($urandom);
        repeat (WIDTH + 1) @(posedge clk);
        @(negedge clk);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_gt", a_gt_b, 0);
        check("rst_lt", a_lt_b, 0);
        check("rst_eq", a_eq_b, 0);
        @(negedge clk);

        // WIDTH=3 legacy case: 4 edges from start to done
        s3_start = 1'b1; s3_a = 3'b010; s3_b = 3'b101; s3_mode = 3'd0;
        @(posedge clk); #1 s3_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("w3_lt_done", s3_done, 1);
        check("w3_lt_result", s3_result, 1);
        check("w3_lt_flag", s3_lt, 1);
        @(negedge clk);
        s3_start = 1'b1; s3_mode = 3'd1;
        @(posedge clk); #1 s3_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("w3_gt_done", s3_done, 1);
        check("w3_gt_result", s3_result, 0);
        @(negedge clk);

        // Directed cases through the scoreboard
        issue(8'hA5, 8'hA5, 3'd2);
        issue(8'hA5, 8'hA5, 3'd3);
        issue(8'h80, 8'h01, 3'd1);
        issue(8'h10, 8'h01, 3'd6);
        issue(8'h00, 8'hFF, 3'd4);
        issue(8'hFF, 8'hFF, 3'd5);
        issue(8'h7F, 8'h80, 3'd0);

        // Start and operand changes during COMPARE are ignored
        start = 1'b1; a = 8'h33; b = 8'h44; mode = 3'd0;
        @(posedge clk); #1;
        start = 1'b0;
        sb_q.push_back('{model(8'h33, 8'h44, 3'd0), cyc + WIDTH});
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'hF0; b = 8'h01; mode = 3'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (WIDTH - 3) @(posedge clk);
        @(negedge clk);
        check("busy_in_done", busy, 1);
        @(negedge clk);
        check("idle_after_ignored", busy, 0);
        @(negedge clk);

        // Reset in the middle of COMPARE drops the comparison and the outputs
        issue(8'h90, 8'h20, 3'd1);
        start = 1'b1; a = 8'h12; b = 8'h34; mode = 3'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_out", {result, a_gt_b, a_lt_b, a_eq_b}, 0);
        repeat (WIDTH + 2) @(negedge clk);
        issue(8'h12, 8'h34, 3'd0);

        // Randomised traffic
        for (int i = 0; i < 150; i++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
            issue(ra, rb, 3'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
